// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: opcodes, ALU operation codes and
// control FSM states.
package cpu_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_STORE = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_JZ    = 3'b110;
    localparam logic [2:0] OP_OUT   = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_PASS = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH    = 3'd0,
        ST_DECODE   = 3'd1,
        ST_MEM_RD   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MEM_WR   = 3'd4,
        ST_OUT_WAIT = 3'd5,
        ST_UNUSED   = 3'd6,
        ST_FAULT    = 3'd7
    } state_e;

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts stalled cycles of a RAM access and flags expiry when the stall
// reaches the limit; a MEM_TIMEOUT of 0 disables expiry.
module mem_timeout_ctr #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = (MEM_TIMEOUT != 0) && enable && (cnt_q == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_fsm_mc.sv
// Multi-cycle fetch/decode/execute controller for the accumulator CPU with
// RAM/UART handshakes and a sticky fault on RAM timeout.
module control_fsm_mc
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W+2:0] instruction,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] acc_data,
    input  logic              mem_ready,
    input  logic              uart_busy,
    output logic [1:0]        alu_op,
    output logic              acc_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              pc_write,
    output logic              pc_inc,
    output logic              ir_load,
    output logic              uart_send,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] new_pc,
    output logic              instr_done,
    output logic              fault,
    output logic [2:0]        state_dbg
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam int unsigned LIMIT = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    state_e            state_q, state_d;
    logic [ADDR_W+2:0] ir_q, ir_d;
    logic [2:0]        opcode;
    logic              tmo_clear, tmo_en, tmo_expired;

    assign opcode    = ir_q[ADDR_W+2 -: 3];
    assign mem_addr  = ir_q[ADDR_W-1:0];
    assign new_pc    = ir_q[ADDR_W-1:0];
    assign state_dbg = state_q;

    mem_timeout_ctr #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .limit   (LIMIT_C),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        alu_op     = ALU_ADD;
        acc_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        pc_write   = 1'b0;
        pc_inc     = 1'b0;
        ir_load    = 1'b0;
        uart_send  = 1'b0;
        instr_done = 1'b0;
        fault      = 1'b0;
        tmo_clear  = 1'b1;
        tmo_en     = 1'b0;
        case (state_q)
            ST_FETCH: begin
                // Reset holds state at FETCH, so ir_load is the only output that needs gating.
                ir_load = instr_valid && reset;
                if (instr_valid) begin
                    ir_d    = instruction;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_NOP: begin
                        pc_inc     = 1'b1;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OP_JMP: begin
                        pc_write   = 1'b1;
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OP_JZ: begin
                        pc_write   = (acc_data == '0);
                        pc_inc     = (acc_data != '0);
                        instr_done = 1'b1;
                        state_d    = ST_FETCH;
                    end
                    OP_LOAD, OP_ADD, OP_SUB: state_d = ST_MEM_RD;
                    OP_STORE:                state_d = ST_MEM_WR;
                    OP_OUT:                  state_d = ST_OUT_WAIT;
                    default:                 state_d = ST_FAULT;
                endcase
            end
            ST_MEM_RD: begin
                mem_read  = 1'b1;
                tmo_clear = 1'b0;
                tmo_en    = !mem_ready;
                if (mem_ready) begin
                    state_d = ST_EXEC;
                end else if (tmo_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_EXEC: begin
                acc_write  = 1'b1;
                alu_op     = (opcode == OP_LOAD) ? ALU_PASS :
                             (opcode == OP_SUB)  ? ALU_SUB  : ALU_ADD;
                pc_inc     = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                tmo_clear = 1'b0;
                tmo_en    = !mem_ready;
                if (mem_ready) begin
                    pc_inc     = 1'b1;
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end else if (tmo_expired) begin
                    state_d = ST_FAULT;
                end
            end
            ST_OUT_WAIT: begin
                if (!uart_busy) begin
                    uart_send  = 1'b1;
                    pc_inc     = 1'b1;
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end
            end
            ST_FAULT: fault = 1'b1;
            default:  state_d = ST_FAULT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_control_fsm_mc.sv
// Randomized scoreboard bench for control_fsm_mc: a per-instruction reference
// model predicts the completion strobes, latency and handshake cycle counts.
module tb_control_fsm_mc;
    import cpu_pkg::*;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned MEM_TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W+2:0] instruction;
    logic              instr_valid;
    logic [DATA_W-1:0] acc_data;
    logic              mem_ready;
    logic              uart_busy;
    logic [1:0]        alu_op;
    logic              acc_write, mem_read, mem_write, pc_write, pc_inc;
    logic              ir_load, uart_send, instr_done, fault;
    logic [ADDR_W-1:0] mem_addr, new_pc;
    logic [2:0]        state_dbg;

    control_fsm_mc #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .acc_data    (acc_data),
        .mem_ready   (mem_ready),
        .uart_busy   (uart_busy),
        .alu_op      (alu_op),
        .acc_write   (acc_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .pc_write    (pc_write),
        .pc_inc      (pc_inc),
        .ir_load     (ir_load),
        .uart_send   (uart_send),
        .mem_addr    (mem_addr),
        .new_pc      (new_pc),
        .instr_done  (instr_done),
        .fault       (fault),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pc_write;
        logic        pc_inc;
        logic        acc_write;
        logic        uart_send;
        logic        mem_write;
        logic [1:0]  alu_op;
        logic [4:0]  opr;
        int unsigned lat;
        int unsigned rd_cyc;
        int unsigned wr_cyc;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    int unsigned done_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {8'd0, alu_op, acc_write, mem_read, mem_write, pc_write, pc_inc, ir_load,
                   uart_send, mem_addr, new_pc, instr_done, fault, state_dbg}, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: measures each instruction from ir_load to instr_done and scores it.
    int unsigned m_lat, m_rd, m_wr;
    bit          m_active = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            m_active = 1'b0;
        end else begin
            if (ir_load) begin
                m_active = 1'b1;
                m_lat = 0;
                m_rd  = 0;
                m_wr  = 0;
            end
            if (m_active) begin
                m_lat++;
                if (mem_read)  m_rd++;
                if (mem_write) m_wr++;
            end
            if (instr_done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("pc_write",  pc_write,  e.pc_write);
                    chk("pc_inc",    pc_inc,    e.pc_inc);
                    chk("acc_write", acc_write, e.acc_write);
                    chk("uart_send", uart_send, e.uart_send);
                    chk("mem_write", mem_write, e.mem_write);
                    chk("alu_op",    alu_op,    e.alu_op);
                    chk("new_pc",    new_pc,    e.opr);
                    chk("mem_addr",  mem_addr,  e.opr);
                    chk("latency",   m_lat,     e.lat);
                    chk("rd_cycles", m_rd,      e.rd_cyc);
                    chk("wr_cycles", m_wr,      e.wr_cyc);
                end
                m_active = 1'b0;
                done_cnt++;
            end
        end
    end

    // w = stalled RAM cycles before mem_ready, b = busy cycles in the UART wait.
    task automatic issue(input logic [2:0] op, input logic [4:0] opr, input logic [7:0] acc,
                         input int unsigned w, input int unsigned b);
        exp_t        e;
        int unsigned start;
        int unsigned k;
        bit          is_rd;
        is_rd       = (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
        e.pc_write  = (op == OP_JMP) || (op == OP_JZ && acc == 8'd0);
        e.pc_inc    = !e.pc_write;
        e.acc_write = is_rd;
        e.uart_send = (op == OP_OUT);
        e.mem_write = (op == OP_STORE);
        e.alu_op    = (op == OP_LOAD) ? 2'b10 : (op == OP_SUB) ? 2'b01 : 2'b00;
        e.opr       = opr;
        e.rd_cyc    = is_rd ? w + 1 : 0;
        e.wr_cyc    = (op == OP_STORE) ? w + 1 : 0;
        if (op == OP_STORE)  e.lat = 3 + w;
        else if (op == OP_OUT) e.lat = 3 + b;
        else if (is_rd)      e.lat = 4 + w;
        else                 e.lat = 2;
        sb.push_back(e);
        start = done_cnt;

        repeat ($urandom_range(0, 2)) step();
        instruction = {op, opr};
        acc_data    = acc;
        instr_valid = 1'b1;
        uart_busy   = (op == OP_OUT) && (b != 0);
        #1;
        k = 0;
        while (!ir_load && k < 20) begin step(); k++; end
        chk("ir_load_seen", ir_load, 1'b1);
        step();
        instr_valid = 1'b0;
        instruction = 8'($urandom);

        if (is_rd || op == OP_STORE) begin
            k = 0;
            while (!(mem_read || mem_write) && k < 10) begin step(); k++; end
            repeat (w) step();
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
        end else if (op == OP_OUT) begin
            k = 0;
            while (state_dbg != 3'd5 && k < 10) begin step(); k++; end
            repeat (b) step();
            uart_busy = 1'b0;
        end

        k = 0;
        while (done_cnt == start && k < 40) begin step(); k++; end
        chk("done_seen", done_cnt != start, 1'b1);
        uart_busy = 1'b0;
        mem_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned wr;
        logic [2:0]  op;
        logic [7:0]  acc;

        reset       = 1'b0;
        instr_valid = 1'b1;
        instruction = 8'hFF;
        acc_data    = 8'd0;
        mem_ready   = 1'b1;
        uart_busy   = 1'b0;
        #3;
        chk_zero("reset_outputs");
        mem_ready   = 1'b0;
        instr_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("state_after_reset", state_dbg, 3'd0);

        issue(OP_NOP,   5'h00, 8'h00, 0, 0);
        issue(OP_JMP,   5'h15, 8'h00, 0, 0);
        issue(OP_JZ,    5'h03, 8'h00, 0, 0);
        issue(OP_JZ,    5'h03, 8'h80, 0, 0);
        issue(OP_ADD,   5'h07, 8'h11, 3, 0);
        issue(OP_OUT,   5'h00, 8'h22, 0, 5);
        issue(OP_STORE, 5'h0A, 8'h33, 3, 0);
        issue(OP_LOAD,  5'h01, 8'h44, 0, 0);
        issue(OP_SUB,   5'h1E, 8'h55, 1, 0);
        issue(OP_OUT,   5'h02, 8'h66, 0, 0);

        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            acc = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            issue(op, 5'($urandom), acc, $urandom_range(0, 3), $urandom_range(0, 5));
        end

        // Reset in the middle of a RAM read.
        instruction = {OP_LOAD, 5'h09};
        instr_valid = 1'b1;
        #1;
        step();
        instr_valid = 1'b0;
        step();
        chk("read_before_reset", mem_read, 1'b1);
        step();
        #2;
        reset       = 1'b0;
        instr_valid = 1'b1;
        #1;
        chk_zero("reset_mid_mem_rd");
        step();
        step();
        instr_valid = 1'b0;
        reset       = 1'b1;
        #1;
        chk("state_after_abort", state_dbg, 3'd0);
        repeat (3) begin
            step();
            chk("no_read_after_reset", mem_read, 1'b0);
        end
        issue(OP_LOAD, 5'h09, 8'h01, 2, 0);

        // RAM write that never completes traps into the fault state.
        instruction = {OP_STORE, 5'h1F};
        instr_valid = 1'b1;
        mem_ready   = 1'b0;
        #1;
        step();
        instr_valid = 1'b0;
        wr = 0;
        repeat (12) begin
            step();
            if (mem_write) wr++;
        end
        chk("fault_wr_cycles", wr, 32'd4);
        chk("fault_flag", fault, 1'b1);
        chk("fault_state", state_dbg, 3'd7);
        instr_valid = 1'b1;
        mem_ready   = 1'b1;
        repeat (4) begin
            step();
            chk("fault_quiet", {alu_op, acc_write, mem_read, mem_write, pc_write, pc_inc,
                                ir_load, uart_send, instr_done, fault}, 11'h001);
        end
        reset = 1'b0;
        #2;
        chk("fault_cleared", fault, 1'b0);
        step();
        instr_valid = 1'b0;
        reset       = 1'b1;

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/control_fsm_mc.md
Name: control_fsm_mc

Overview:
Multi-cycle, parametrised control unit for the accumulator CPU. It replaces single-cycle combinational decode with a registered-state FSM that fetches, decodes and executes one instruction per pass. It waits on RAM and UART handshakes and traps to a sticky fault state on a memory timeout. It sits between the instruction ROM, RAM, accumulator/ALU, PC and UART transmitter.

Parameters:
DATA_W, 8, accumulator/data width (used for the JZ zero test)
ADDR_W, 5, operand/address width; instruction width is 3+ADDR_W
MEM_TIMEOUT, 16, maximum cycles spent in MEM_RD/MEM_WR without mem_ready; 0 disables the timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
instruction  in  3+ADDR_W  ROM word; [top 3] opcode, [ADDR_W-1:0] operand
instr_valid  in  1  ROM word valid this cycle
acc_data  in  DATA_W  accumulator value
mem_ready  in  1  RAM access complete
uart_busy  in  1  UART cannot accept a byte
alu_op  out  2  00 ADD, 01 SUB, 10 PASS (LOAD)
acc_write  out  1  load ACC this cycle
mem_read  out  1  RAM read request (level, held until ready)
mem_write  out  1  RAM write request (level, held until ready)
pc_write  out  1  PC <= new_pc
pc_inc  out  1  PC <= PC+1
ir_load  out  1  instruction accepted into IR
uart_send  out  1  one-cycle send strobe
mem_addr  out  ADDR_W  IR operand
new_pc  out  ADDR_W  IR operand
instr_done  out  1  pulse on the last cycle of each instruction
fault  out  1  sticky memory-timeout flag
state_dbg  out  3  current state encoding

Behaviour:
- Registers: state, IR (3+ADDR_W bits), timeout counter. Outputs are combinational from state, IR and the handshake inputs.
- Reset (reset=0, async): state=FETCH, IR=0, counter=0. While reset is asserted all outputs are 0, including ir_load. mem_addr=new_pc=0 and state_dbg=0.
- Opcodes: 000 NOP, 001 LOAD, 010 STORE, 011 ADD, 100 SUB, 101 JMP, 110 JZ, 111 OUT.
- State encodings: FETCH=0, DECODE=1, MEM_RD=2, EXEC=3, MEM_WR=4, OUT_WAIT=5, FAULT=7. Code 6 is unused and goes to FAULT.
- FETCH: ir_load=instr_valid. If instr_valid, IR<=instruction and go to DECODE; otherwise stay.
- DECODE (one cycle):
  - NOP: pc_inc, instr_done; go to FETCH.
  - JMP: pc_write, instr_done; go to FETCH.
  - JZ: if acc_data==0 (all DATA_W bits), pc_write, else pc_inc; instr_done; go to FETCH. acc_data is sampled in this cycle only.
  - LOAD/ADD/SUB: go to MEM_RD. STORE: go to MEM_WR. OUT: go to OUT_WAIT.
- MEM_RD: mem_read=1. If mem_ready, go to EXEC.
- EXEC: acc_write=1; alu_op=10 for LOAD, 00 for ADD, 01 for SUB; pc_inc; instr_done; go to FETCH.
- MEM_WR: mem_write=1. If mem_ready, pc_inc and instr_done in the same cycle, then go to FETCH.
- OUT_WAIT: if !uart_busy, uart_send=1, pc_inc, instr_done, go to FETCH; otherwise hold with no timeout.
- alu_op is 00 in every state other than EXEC.
- Timeout counter:
  - Cleared on entry to MEM_RD/MEM_WR.
  - Increments each cycle in those states while mem_ready=0.
  - If it reaches MEM_TIMEOUT-1 and mem_ready=0 in that cycle, go to FAULT.
  - mem_ready in the same cycle as that limit wins: normal progress, no fault.
  - Counter width is clog2(MEM_TIMEOUT+1).
- FAULT: fault=1, all strobes 0. Only reset exits it.
- pc_write and pc_inc are never both 1. Exactly one instr_done per instruction.
- Latency with zero wait: NOP/JMP/JZ 2 cycles, STORE/OUT 3, LOAD/ADD/SUB 4.
- Reset mid-instruction aborts immediately; no partial strobe survives.

Decomposition:
- Shared package cpu_pkg: opcode localparams, ALU_ADD/ALU_SUB/ALU_PASS codes, state encodings.
- One sub-module: mem_timeout_ctr (clear, enable, limit in; expired out), parametrised by MEM_TIMEOUT.

Test Plan:
- Reset mid-MEM_RD -> all outputs 0 immediately; after release, state_dbg=0 and no mem_read until the next LOAD decode.
- NOP (0x00) then JMP 0x15 (0xB5), instr_valid=1 -> pc_inc, then pc_write with new_pc=0x15, each 2 cycles; instr_done pulses at cycles 2 and 4.
- JZ 0x03 (0xC3) with acc_data=0x00 -> pc_write, new_pc=3; repeat with acc_data=0x80 -> pc_inc only.
- ADD 0x07 (0x67), mem_ready delayed 3 cycles -> mem_read held 4 cycles with mem_addr=7, then one EXEC cycle with acc_write=1, alu_op=00, pc_inc=1.
- OUT (0xE0) with uart_busy=1 for 5 cycles -> uart_send single pulse in the first cycle uart_busy=0, pc_inc in the same cycle.
- STORE 0x1F (0x5F), MEM_TIMEOUT=4, mem_ready never asserted -> mem_write for 4 cycles, then fault=1, state_dbg=7, no further strobes until reset.
